// File: rtl/word_unpacker.sv
// word_unpacker
//   Serializes BYTE_W*NBYTES-bit words into a stream of BYTE_W-bit bytes,
//   most significant byte first. Upstream hands over a word with a
//   valid/ready handshake, and downstream takes bytes with a valid/ready
//   handshake. After the final byte of a word, the next word is taken in the
//   same cycle, so back-to-back words stream without a bubble.
//
//   state | meaning
//   IDLE  | no word held, waiting for upstream (word_ready=1, valid_out=0)
//   SEND  | shadow word being serialized, byte index byte_cnt_q
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   valid_in   in   data_in holds a word offered by upstream
//   data_in    in   input word
//   word_ready out  word accepted this cycle when valid_in=1 (combinational)
//   valid_out  out  data_out holds a valid byte (registered)
//   data_out   out  current byte (registered)
//   ready_in   in   downstream accepts data_out this cycle
//   last_out   out  data_out is the final byte of the word (registered)
module word_unpacker #(
  parameter int BYTE_W = 8,
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic [BYTE_W*NBYTES-1:0] data_in,
  output logic                     word_ready,
  output logic                     valid_out,
  output logic [BYTE_W-1:0]        data_out,
  input  logic                     ready_in,
  output logic                     last_out
);

  localparam int WORD_W = BYTE_W * NBYTES;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [BYTE_W-1:0]   data_out_q, data_out_d;
  logic                valid_out_q, valid_out_d;
  logic                last_out_q, last_out_d;

  logic                is_last;
  logic [CNT_W-1:0]    cnt_inc;

  // Byte idx of a word, counting from the most significant byte.
  function automatic logic [BYTE_W-1:0] pick_byte(input logic [WORD_W-1:0] w,
                                                  input logic [CNT_W-1:0]  idx);
    pick_byte = w[(NBYTES - 1 - int'(idx)) * BYTE_W +: BYTE_W];
  endfunction

  assign is_last = (byte_cnt_q == LAST_IDX);
  assign cnt_inc = byte_cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    data_out_d  = data_out_q;
    valid_out_d = valid_out_q;
    last_out_d  = last_out_q;
    word_ready  = 1'b0;

    case (state_q)
      IDLE: begin
        word_ready = 1'b1;
        if (valid_in) begin
          state_d     = SEND;
          word_d      = data_in;
          byte_cnt_d  = '0;
          valid_out_d = 1'b1;
          data_out_d  = pick_byte(data_in, '0);
          last_out_d  = (LAST_IDX == '0);
        end
      end

      SEND: begin
        // The final byte leaving frees the shadow register in the same cycle.
        word_ready = is_last & ready_in;
        if (ready_in) begin
          if (!is_last) begin
            byte_cnt_d = cnt_inc;
            data_out_d = pick_byte(word_q, cnt_inc);
            last_out_d = (cnt_inc == LAST_IDX);
          end else if (valid_in) begin
            word_d      = data_in;
            byte_cnt_d  = '0;
            valid_out_d = 1'b1;
            data_out_d  = pick_byte(data_in, '0);
            last_out_d  = (LAST_IDX == '0);
          end else begin
            state_d     = IDLE;
            valid_out_d = 1'b0;
            last_out_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d     = IDLE;
        valid_out_d = 1'b0;
        last_out_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      last_out_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      last_out_q  <= last_out_d;
    end
  end

  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;
  assign last_out  = last_out_q;

endmodule

// File: tb/tb_word_unpacker.sv
// Bench for word_unpacker: expected bytes (with last flag) and sent words are
// queued when a word is accepted; a negedge monitor pops and compares bytes,
// checks word_ready, and reassembles words to compare against the sent ones.
module tb_word_unpacker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = '0;
  logic        word_ready;
  logic        valid_out;
  logic [7:0]  data_out;
  logic        ready_in;
  logic        last_out;

  logic        ready_man = 1'b1;
  logic        rnd_mode  = 1'b0;
  logic        rnd_r     = 1'b1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int xfer  = 0;

  logic [8:0]  sb[$];   // {byte, last}
  logic [31:0] wq[$];
  logic [31:0] asm_w = '0;

  assign ready_in = rnd_mode ? rnd_r : ready_man;

  word_unpacker #(.BYTE_W(8), .NBYTES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .word_ready (word_ready),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .ready_in   (ready_in),
    .last_out   (last_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    rnd_r = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst) begin
      asm_w = '0;
    end else if (valid_out && ready_in) begin
      chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("data_out", 32'(data_out), 32'(e[8:1]));
        chk("last_out", 32'(last_out), 32'(e[0]));
        chk("word_ready_send", 32'(word_ready), 32'(e[0]));
        xfer++;
        asm_w = {asm_w[23:0], data_out};
        if (e[0]) begin
          chk("wq_nonempty", 32'(wq.size() > 0), 32'd1);
          if (wq.size() > 0) chk("loopback_word", asm_w, wq.pop_front());
        end
      end
    end else if (valid_out) begin
      chk("word_ready_stall", 32'(word_ready), 32'd0);
    end else begin
      chk("word_ready_idle", 32'(word_ready), 32'd1);
    end
  end

  task automatic offer(input logic [31:0] w, input bit keep);
    bit got = 1'b0;
    valid_in = 1'b1;
    data_in  = w;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (word_ready) got = 1'b1;
    end
    chk("accept_timeout", 32'(got), 32'd1);
    if (got) begin
      for (int i = 0; i < 4; i++) sb.push_back({w[(3-i)*8 +: 8], i == 3});
      wq.push_back(w);
      @(posedge clk);
      #1;
      chk("first_valid", 32'(valid_out), 32'd1);
      chk("first_byte", 32'(data_out), 32'(w[31:24]));
    end
    if (!keep) valid_in = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 500 && sb.size() > 0; k++) @(posedge clk);
    #1;
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    chk("drain_wq_empty", 32'(wq.size()), 32'd0);
  endtask

  initial begin
    int c0, n0, r;

    // reset values
    #2 rst = 1'b0;
    #1;
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_last_out", 32'(last_out), 32'd0);
    chk("rst_word_ready", 32'(word_ready), 32'd1);
    #19 rst = 1'b1;
    @(posedge clk); #1;

    // T2 single word, no bubble, then idle
    offer(32'hA1B2C3D4, 1'b0);
    c0 = cyc; n0 = xfer;
    repeat (4) @(posedge clk);
    #1;
    chk("t2_bytes_in_4", 32'(xfer - n0), 32'd4);
    chk("t2_idle_after", 32'(valid_out), 32'd0);

    // T3 back-to-back words with valid_in held high
    offer(32'h01020304, 1'b1);
    c0 = cyc; n0 = xfer;
    offer(32'h05060708, 1'b0);
    r = c0 + 8 - cyc;
    repeat (r) @(posedge clk);
    #1;
    chk("t3_bytes_in_8", 32'(xfer - n0), 32'd8);
    chk("t3_idle_after", 32'(valid_out), 32'd0);

    // T4 stall while B2 is shown
    offer(32'hA1B2C3D4, 1'b0);
    @(posedge clk); #1;
    ready_man = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t4_hold_data", 32'(data_out), 32'hB2);
      chk("t4_hold_valid", 32'(valid_out), 32'd1);
      chk("t4_hold_last", 32'(last_out), 32'd0);
    end
    ready_man = 1'b1;
    drain();

    // T5 upstream changes data_in while busy
    offer(32'h11223344, 1'b1);
    offer(32'hFFFFFFFF, 1'b0);
    drain();

    // T1 reset mid-word
    offer(32'hCAFEBABE, 1'b0);
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1;
    chk("t1_valid_out", 32'(valid_out), 32'd0);
    chk("t1_data_out", 32'(data_out), 32'd0);
    chk("t1_last_out", 32'(last_out), 32'd0);
    chk("t1_word_ready", 32'(word_ready), 32'd1);
    sb.delete();
    wq.delete();
    @(negedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    offer(32'h0F1E2D3C, 1'b0);
    drain();

    // T6 random words with random downstream backpressure
    rnd_mode = 1'b1;
    for (int i = 0; i < 16; i++) offer($urandom, i < 15);
    drain();
    rnd_mode = 1'b0;

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
